// File: rtl/dut_dacx0504.sv
// Quad 16-bit DAC register front end: SPI slave oversampled in the SYS_CLK domain,
// 24-bit frame decode, buffered/synchronous DAC loading, LDAC, soft reset and readback.
module dut_dacx0504 #(
  parameter logic [15:0] DEVICE_ID = 16'h0A14
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic        DAC_CLK,
  input  logic        DAC_SDI,
  input  logic        DAC_CS_N,
  output logic        DAC_SDO,
  output logic [15:0] DAC0_OUT,
  output logic [15:0] DAC1_OUT,
  output logic [15:0] DAC2_OUT,
  output logic [15:0] DAC3_OUT,
  output logic        FRAME_ERR
);

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned NUM_DAC    = 4;

  // Two synchronizer stages plus one history stage for edge detection
  logic [2:0] clk_sync;
  logic [2:0] cs_sync;
  logic [1:0] sdi_sync;

  logic clk_fall_c;
  logic clk_rise_c;
  logic cs_fall_c;
  logic cs_rise_c;

  logic                  frame_active;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rb_word;

  logic              exec_valid;
  logic              exec_rw;
  logic [ADDR_W-1:0] exec_addr;
  logic [DATA_W-1:0] exec_data;

  logic [NUM_DAC-1:0] sync_reg;
  logic [DATA_W-1:0]  config_reg;
  logic [DATA_W-1:0]  gain_reg;
  logic [DATA_W-1:0]  dac_buf [NUM_DAC];
  logic [DATA_W-1:0]  dac_out [NUM_DAC];
  logic               frame_err;

  logic [DATA_W-1:0]  rd_data_c;

  assign clk_fall_c =  clk_sync[2] & ~clk_sync[1];
  assign clk_rise_c = ~clk_sync[2] &  clk_sync[1];
  assign cs_fall_c  =  cs_sync[2]  & ~cs_sync[1];
  assign cs_rise_c  = ~cs_sync[2]  &  cs_sync[1];

  assign DAC_SDO   = tx_shift[FRAME_BITS-1];
  assign DAC0_OUT  = dac_out[0];
  assign DAC1_OUT  = dac_out[1];
  assign DAC2_OUT  = dac_out[2];
  assign DAC3_OUT  = dac_out[3];
  assign FRAME_ERR = frame_err;

  // Readback mux; DAC addresses return the buffer, not the loaded code
  always_comb begin
    rd_data_c = '0;
    case (exec_addr)
      4'h1:                   rd_data_c = DEVICE_ID;
      4'h2:                   rd_data_c = {(DATA_W-NUM_DAC)'(0), sync_reg};
      4'h3:                   rd_data_c = config_reg;
      4'h4:                   rd_data_c = gain_reg;
      4'h8, 4'h9, 4'hA, 4'hB: rd_data_c = dac_buf[exec_addr[1:0]];
      default:                rd_data_c = '0;
    endcase
  end

  // CS sync resets low so a frame only starts after CS_N has been seen high
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync <= '0;
      cs_sync  <= '0;
      sdi_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], DAC_CLK};
      cs_sync  <= {cs_sync[1:0], DAC_CS_N};
      sdi_sync <= {sdi_sync[0], DAC_SDI};
    end
  end

  // Frame capture, readback shifting and register execution
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_active <= 1'b0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      tx_shift     <= '0;
      rb_word      <= '0;
      exec_valid   <= 1'b0;
      exec_rw      <= 1'b0;
      exec_addr    <= '0;
      exec_data    <= '0;
      sync_reg     <= '0;
      config_reg   <= '0;
      gain_reg     <= '0;
      frame_err    <= 1'b0;
      for (int i = 0; i < NUM_DAC; i++) begin
        dac_buf[i] <= '0;
        dac_out[i] <= '0;
      end
    end else begin
      frame_err  <= 1'b0;
      exec_valid <= 1'b0;

      if (cs_fall_c) begin
        frame_active <= 1'b1;
        bit_cnt      <= '0;
        shift_reg    <= '0;
        tx_shift     <= rb_word;
      end else if (frame_active && cs_rise_c) begin
        frame_active <= 1'b0;
        tx_shift     <= '0;
        rb_word      <= '0;
        if (bit_cnt == CNT_W'(FRAME_BITS)) begin
          exec_valid <= 1'b1;
          exec_rw    <= shift_reg[23];
          exec_addr  <= shift_reg[19:16];
          exec_data  <= shift_reg[15:0];
        end else begin
          frame_err  <= 1'b1;
        end
      end else if (frame_active) begin
        if (clk_fall_c) begin
          shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_sync[1]};
          if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (clk_rise_c) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
      end else begin
        tx_shift <= '0;
      end

      if (exec_valid) begin
        if (exec_rw) begin
          rb_word <= {1'b1, 3'b000, exec_addr, rd_data_c};
        end else begin
          case (exec_addr)
            4'h2: sync_reg   <= exec_data[NUM_DAC-1:0];
            4'h3: config_reg <= exec_data;
            4'h4: gain_reg   <= exec_data;
            4'h5: begin
              // Soft reset wins over LDAC carried in the same write
              if (exec_data[3:0] == 4'b1010) begin
                sync_reg   <= '0;
                config_reg <= '0;
                gain_reg   <= '0;
                rb_word    <= '0;
                for (int i = 0; i < NUM_DAC; i++) begin
                  dac_buf[i] <= '0;
                  dac_out[i] <= '0;
                end
              end else if (exec_data[4]) begin
                for (int i = 0; i < NUM_DAC; i++) begin
                  if (sync_reg[i]) dac_out[i] <= dac_buf[i];
                end
              end
            end
            4'h8, 4'h9, 4'hA, 4'hB: begin
              dac_buf[exec_addr[1:0]] <= exec_data;
              if (!sync_reg[exec_addr[1:0]]) dac_out[exec_addr[1:0]] <= exec_data;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_dacx0504.sv
// Directed bench for dut_dacx0504: SPI frames driven at SYS_CLK/8 with
// hand-computed expected DAC codes, readback words and frame-error pulses.
module tb_dut_dacx0504;

  logic        SYS_CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        DAC_CLK = 1'b0;
  logic        DAC_SDI = 1'b0;
  logic        DAC_CS_N = 1'b1;
  logic        DAC_SDO;
  logic [15:0] DAC0_OUT, DAC1_OUT, DAC2_OUT, DAC3_OUT;
  logic        FRAME_ERR;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  dut_dacx0504 #(.DEVICE_ID(16'h0A14)) dut (
    .SYS_CLK  (SYS_CLK),
    .RESET_N  (RESET_N),
    .DAC_CLK  (DAC_CLK),
    .DAC_SDI  (DAC_SDI),
    .DAC_CS_N (DAC_CS_N),
    .DAC_SDO  (DAC_SDO),
    .DAC0_OUT (DAC0_OUT),
    .DAC1_OUT (DAC1_OUT),
    .DAC2_OUT (DAC2_OUT),
    .DAC3_OUT (DAC3_OUT),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  always @(negedge SYS_CLK) if (FRAME_ERR === 1'b1) err_pulses++;

  initial begin
    #2ms;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] dac_out(input int i);
    case (i)
      0:       return DAC0_OUT;
      1:       return DAC1_OUT;
      2:       return DAC2_OUT;
      default: return DAC3_OUT;
    endcase
  endfunction

  // Master drives SDI on DAC_CLK rise, samples SDO just before each rise
  task automatic spi_frame(input logic [31:0] word, input int nbits,
                           output logic [23:0] rx);
    rx = '0;
    @(negedge SYS_CLK);
    DAC_CS_N = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      if (i < 24) rx[23-i] = DAC_SDO;
      DAC_CLK = 1'b1;
      DAC_SDI = word[nbits-1-i];
      #40;
      DAC_CLK = 1'b0;
      #40;
    end
    #40;
    DAC_CS_N = 1'b1;
    #80;
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dac_out(i) !== 16'h0000) begin
        errors++;
        $display("FAIL reset_dac%0d got %h exp 0000", i, dac_out(i));
      end
    end
    checks++;
    if (DAC_SDO !== 1'b0) begin errors++; $display("FAIL reset_sdo got %b exp 0", DAC_SDO); end
    checks++;
    if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", FRAME_ERR); end
    #43;
    RESET_N = 1'b1;
    #100;
  endtask

  task automatic test_dac_writes();
    logic [23:0] rx;
    logic [23:0] frames [4] = '{24'h081234, 24'h095678, 24'h0AABCD, 24'h0BBEEF};
    logic [15:0] exp    [4] = '{16'h1234, 16'h5678, 16'hABCD, 16'hBEEF};
    int e0 = err_pulses;
    for (int i = 0; i < 4; i++) spi_frame({8'h00, frames[i]}, 24, rx);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dac_out(i) !== exp[i]) begin
        errors++;
        $display("FAIL write_dac%0d got %h exp %h", i, dac_out(i), exp[i]);
      end
    end
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL write_no_err got %0d exp %0d", err_pulses, e0);
    end
  endtask

  task automatic test_readback();
    logic [23:0] rx;
    logic [23:0] frames [7] = '{24'h810000, 24'h830000, 24'h8A0000, 24'h860000,
                                24'h000000, 24'h000000, 24'h810000};
    logic [23:0] exp    [7] = '{24'h000000, 24'h810A14, 24'h835A5A, 24'h8AABCD,
                                24'h860000, 24'h000000, 24'h000000};
    spi_frame(32'h00035A5A, 24, rx);
    for (int i = 0; i < 7; i++) begin
      spi_frame({8'h00, frames[i]}, 24, rx);
      checks++;
      if (rx !== exp[i]) begin
        errors++;
        $display("FAIL readback_%0d got %h exp %h", i, rx, exp[i]);
      end
    end
    spi_frame(32'h00000000, 24, rx);
    checks++;
    if (rx !== 24'h810A14) begin errors++; $display("FAIL readback_id_nop got %h exp 810a14", rx); end
    checks++;
    if (DAC_SDO !== 1'b0) begin errors++; $display("FAIL sdo_idle got %b exp 0", DAC_SDO); end
  endtask

  task automatic test_frame_err();
    logic [23:0] rx;
    int e0 = err_pulses;
    spi_frame(32'h00000899, 16, rx);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL short_frame_err got %0d exp %0d", err_pulses, e0 + 1);
    end
    checks++;
    if (DAC0_OUT !== 16'h1234) begin errors++; $display("FAIL short_frame_dac0 got %h exp 1234", DAC0_OUT); end
    spi_frame(32'h00081111, 25, rx);
    checks++;
    if (err_pulses !== e0 + 2) begin
      errors++;
      $display("FAIL long_frame_err got %0d exp %0d", err_pulses, e0 + 2);
    end
    checks++;
    if (DAC0_OUT !== 16'h1234) begin errors++; $display("FAIL long_frame_dac0 got %h exp 1234", DAC0_OUT); end
  endtask

  task automatic test_sync_ldac();
    logic [23:0] rx;
    spi_frame(32'h00020001, 24, rx);
    spi_frame(32'h00084444, 24, rx);
    checks++;
    if (DAC0_OUT !== 16'h1234) begin errors++; $display("FAIL sync_hold_dac0 got %h exp 1234", DAC0_OUT); end
    spi_frame(32'h00880000, 24, rx);
    spi_frame(32'h00091111, 24, rx);
    checks++;
    if (rx !== 24'h884444) begin errors++; $display("FAIL sync_buf_read got %h exp 884444", rx); end
    checks++;
    if (DAC1_OUT !== 16'h1111) begin errors++; $display("FAIL async_dac1 got %h exp 1111", DAC1_OUT); end
    spi_frame(32'h00050010, 24, rx);
    checks++;
    if (DAC0_OUT !== 16'h4444) begin errors++; $display("FAIL ldac_dac0 got %h exp 4444", DAC0_OUT); end
    checks++;
    if (DAC2_OUT !== 16'hABCD) begin errors++; $display("FAIL ldac_dac2 got %h exp abcd", DAC2_OUT); end
  endtask

  task automatic test_soft_reset();
    logic [23:0] rx;
    logic [23:0] rd_frames [4] = '{24'h820000, 24'h840000, 24'h880000, 24'h000000};
    logic [23:0] exp       [4] = '{24'h000000, 24'h820000, 24'h840000, 24'h880000};
    spi_frame(32'h0004FFFF, 24, rx);
    spi_frame(32'h00087777, 24, rx);
    spi_frame(32'h0005001A, 24, rx);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dac_out(i) !== 16'h0000) begin
        errors++;
        $display("FAIL soft_reset_dac%0d got %h exp 0000", i, dac_out(i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      spi_frame({8'h00, rd_frames[i]}, 24, rx);
      checks++;
      if (rx !== exp[i]) begin
        errors++;
        $display("FAIL soft_reset_read%0d got %h exp %h", i, rx, exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] rx;
    logic [23:0] word = 24'h08AAAA;
    spi_frame(32'h000B3333, 24, rx);
    checks++;
    if (DAC3_OUT !== 16'h3333) begin errors++; $display("FAIL pre_reset_dac3 got %h exp 3333", DAC3_OUT); end
    @(negedge SYS_CLK);
    DAC_CS_N = 1'b0;
    #80;
    for (int i = 0; i < 12; i++) begin
      DAC_CLK = 1'b1;
      DAC_SDI = word[23-i];
      #40;
      DAC_CLK = 1'b0;
      #40;
    end
    RESET_N = 1'b0;
    #12;
    checks++;
    if (DAC3_OUT !== 16'h0000) begin errors++; $display("FAIL mid_reset_dac3 got %h exp 0000", DAC3_OUT); end
    checks++;
    if (DAC_SDO !== 1'b0) begin errors++; $display("FAIL mid_reset_sdo got %b exp 0", DAC_SDO); end
    #28;
    RESET_N = 1'b1;
    #40;
    DAC_CS_N = 1'b1;
    #80;
    spi_frame(32'h00082222, 24, rx);
    checks++;
    if (DAC0_OUT !== 16'h2222) begin errors++; $display("FAIL post_reset_dac0 got %h exp 2222", DAC0_OUT); end
    checks++;
    if (DAC3_OUT !== 16'h0000) begin errors++; $display("FAIL post_reset_dac3 got %h exp 0000", DAC3_OUT); end
  endtask

  initial begin
    test_reset();
    test_dac_writes();
    test_readback();
    test_frame_err();
    test_sync_ldac();
    test_soft_reset();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
